// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with one outstanding imem request, one-entry skid buffer and IF/ID register
// Ports: clk/rst_n (async active-low); pc_cur in, pc_next out (PC register loads it every cycle);
//   redirect_valid/redirect_pc from execute; stall from hazard unit;
//   imem_req/imem_addr/imem_ready/imem_rvalid/imem_rdata to instruction memory;
//   ifid_valid/ifid_pc/ifid_instr/ifid_pc_plus4 IF/ID register outputs.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_cur,
  output logic [31:0] pc_next,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        ifid_valid,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_plus4
);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_FULL} state_t;
  state_t state, state_nx;
  logic drop, drop_nx;
  logic [31:0] req_pc, buf_pc, buf_instr;
  logic accept, rsp, load, park, xfer, keep_wait;
  assign accept    = state == S_REQ && imem_ready;
  assign rsp       = state == S_WAIT && imem_rvalid;
  assign load      = !redirect_valid && rsp && !drop && (!ifid_valid || !stall);
  assign park      = !redirect_valid && rsp && !drop && ifid_valid && stall;
  assign xfer      = !redirect_valid && state == S_FULL && !stall;
  // a redirect that leaves a request in flight must mark its response for discard
  assign keep_wait = accept || (state == S_WAIT && !imem_rvalid);
  assign imem_req  = rst_n && state == S_REQ;
  assign imem_addr = pc_cur;
  assign pc_next   = !rst_n ? RESET_PC : redirect_valid ? redirect_pc : accept ? pc_cur + 32'd4 : pc_cur;
  always_comb begin
    state_nx = state;
    drop_nx  = drop;
    if (redirect_valid) begin
      state_nx = keep_wait ? S_WAIT : S_REQ;
      drop_nx  = keep_wait;
    end else begin
      state_nx = accept ? S_WAIT : (rsp && (drop || load)) || xfer ? S_REQ : park ? S_FULL : state;
      drop_nx  = rsp ? 1'b0 : drop;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_REQ;
      drop          <= 1'b0;
      req_pc        <= '0;
      buf_pc        <= '0;
      buf_instr     <= '0;
      ifid_valid    <= 1'b0;
      ifid_pc       <= '0;
      ifid_instr    <= '0;
      ifid_pc_plus4 <= '0;
    end else begin
      state <= state_nx;
      drop  <= drop_nx;
      if (accept) req_pc <= pc_cur;
      if (park) begin
        buf_pc    <= req_pc;
        buf_instr <= imem_rdata;
      end
      if (redirect_valid) ifid_valid <= 1'b0;
      else if (load) begin
        ifid_valid    <= 1'b1;
        ifid_pc       <= req_pc;
        ifid_instr    <= imem_rdata;
        ifid_pc_plus4 <= req_pc + 32'd4;
      end else if (xfer) begin
        ifid_valid    <= 1'b1;
        ifid_pc       <= buf_pc;
        ifid_instr    <= buf_instr;
        ifid_pc_plus4 <= buf_pc + 32'd4;
      end else if (!stall) ifid_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scoreboard bench for fetch_stage
module tb_fetch_stage;
  logic clk = 0, rst_n = 0;
  logic [31:0] pc_cur, pc_next, redirect_pc = 0, imem_addr, imem_rdata = 0;
  logic [31:0] ifid_pc, ifid_instr, ifid_pc_plus4;
  logic redirect_valid = 0, stall = 0, imem_req, imem_ready = 0, imem_rvalid = 0, ifid_valid;
  int checks = 0, fails = 0;
  typedef struct packed { logic [31:0] pc; logic [31:0] instr; } exp_t;
  exp_t sb[$];
  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .pc_cur(pc_cur), .pc_next(pc_next),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .ifid_valid(ifid_valid),
    .ifid_pc(ifid_pc), .ifid_instr(ifid_instr), .ifid_pc_plus4(ifid_pc_plus4)
  );
  always #5 clk = ~clk;
  always_ff @(posedge clk or negedge rst_n) pc_cur <= !rst_n ? 32'h0 : pc_next;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    imem_ready = 0; imem_rvalid = 0; redirect_valid = 0; stall = 0;
  endtask
  task automatic check_ifid(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      fails++;
      $error("FAIL %s: observed empty scoreboard expected entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_valid"}, {31'b0, ifid_valid}, 32'd1);
      chk({tag, "_pc"}, ifid_pc, e.pc);
      chk({tag, "_instr"}, ifid_instr, e.instr);
      chk({tag, "_plus4"}, ifid_pc_plus4, e.pc + 32'd4);
    end
  endtask
  task automatic fetch(input logic [31:0] pc, input logic [31:0] data, input string tag);
    imem_ready = 1; #1;
    chk({tag, "_addr"}, imem_addr, pc);
    tick();
    imem_ready = 0; imem_rvalid = 1; imem_rdata = data;
    sb.push_back({pc, data});
    tick();
    imem_rvalid = 0;
    check_ifid(tag);
  endtask
  initial begin
    #12;
    chk("rst_valid", {31'b0, ifid_valid}, 0);
    chk("rst_pc_next", pc_next, 0);
    chk("rst_req", {31'b0, imem_req}, 0);
    @(negedge clk); rst_n = 1;
    tick();
    imem_ready = 1; #1;
    chk("first_req", {31'b0, imem_req}, 1);
    chk("first_addr", imem_addr, 0);
    chk("first_pc_next", pc_next, 4);
    tick();
    imem_ready = 0; imem_rvalid = 1; imem_rdata = 32'h13; #1;
    chk("wait_noreq", {31'b0, imem_req}, 0);
    chk("wait_pc_hold", pc_next, 4);
    sb.push_back({32'h0, 32'h13});
    tick();
    imem_rvalid = 0; #1;
    check_ifid("first");
    chk("next_fetch", imem_addr, 4);
    stall = 1; imem_ready = 1;
    tick();
    imem_ready = 0; imem_rvalid = 1; imem_rdata = 32'hAAAA_AAAA;
    tick();
    imem_rvalid = 0; #1;
    chk("full_hold_pc", ifid_pc, 0);
    chk("full_hold_instr", ifid_instr, 32'h13);
    chk("full_noreq", {31'b0, imem_req}, 0);
    sb.push_back({32'h4, 32'hAAAA_AAAA});
    tick();
    chk("full_still_held", ifid_instr, 32'h13);
    stall = 0;
    tick();
    check_ifid("unstall");
    chk("after_full_req", {31'b0, imem_req}, 1);
    redirect_valid = 1; redirect_pc = 32'h10; #1;
    chk("redir_pc_next", pc_next, 32'h10);
    tick();
    chk("redir_bubble", {31'b0, ifid_valid}, 0);
    idle(); imem_ready = 1;
    tick();
    idle(); redirect_valid = 1; redirect_pc = 32'h100;
    tick();
    idle();
    tick();
    chk("drop_wait_noreq", {31'b0, imem_req}, 0);
    imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 0; #1;
    chk("drop_valid", {31'b0, ifid_valid}, 0);
    chk("drop_req", {31'b0, imem_req}, 1);
    chk("drop_addr", imem_addr, 32'h100);
    fetch(32'h100, 32'h1234_5678, "post_drop");
    imem_ready = 1;
    tick();
    imem_ready = 0; imem_rvalid = 1; imem_rdata = 32'h5555_0000;
    redirect_valid = 1; redirect_pc = 32'h200; stall = 1; #1;
    chk("coinc_pc_next", pc_next, 32'h200);
    tick();
    idle(); #1;
    chk("coinc_valid", {31'b0, ifid_valid}, 0);
    chk("coinc_addr", imem_addr, 32'h200);
    fetch(32'h200, 32'h0BAD_F00D, "coinc_nodrop");
    imem_rvalid = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("nordy_req", {31'b0, imem_req}, 1);
      chk("nordy_pc_next", pc_next, 32'h204);
      tick();
    end
    idle(); redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    idle(); imem_ready = 1; #1;
    chk("wrap_pc_next", pc_next, 0);
    idle();
    fetch(32'hFFFF_FFFC, 32'h0000_0073, "wrap");
    imem_ready = 1;
    tick();
    imem_ready = 0;
    #2 rst_n = 0; #1;
    chk("arst_valid", {31'b0, ifid_valid}, 0);
    chk("arst_pc", ifid_pc, 0);
    chk("arst_instr", ifid_instr, 0);
    chk("arst_plus4", ifid_pc_plus4, 0);
    chk("arst_pc_next", pc_next, 0);
    chk("arst_req", {31'b0, imem_req}, 0);
    @(negedge clk); rst_n = 1;
    tick(); #1;
    chk("rearm_req", {31'b0, imem_req}, 1);
    chk("rearm_addr", imem_addr, 0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
